// File: rtl/qpix_top_rtl.sv
// QPix test-board control core: register-mapped event capture FIFO,
// two 32-bit serial configuration engines, one-shot pads and static levels.
module qpix_top_rtl #(
    parameter int SER_DIV    = 4,
    parameter int LOAD_PULSE = 16,
    parameter int RST_PULSE  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [15:0]   oLVDS,
    input  logic          opad_deltaT,
    input  logic [2047:0] reg_rw,
    output logic [31:0]   fifo_dout,
    output logic          fifo_empty,
    output logic          fifo_full,
    output logic          fifo_ovf,
    output logic [4:0]    fifo_count,
    output logic          opad_CLKin,
    output logic          opad_SDI,
    output logic          opad_loadData,
    output logic          opad_CLKin2,
    output logic          opad_SDI2,
    output logic          opad_loadData2,
    output logic          shift_busy,
    output logic          shift_busy2,
    output logic          opad_RST_EXT,
    output logic          opad_RST_EXT2,
    output logic          opad_startup,
    output logic          opad_startup2
);

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CNTW   = AW + 1;
    localparam int SCW    = $clog2(SER_DIV) + 1;
    localparam int OS_MAX = (LOAD_PULSE > RST_PULSE) ? LOAD_PULSE : RST_PULSE;
    localparam int OW     = $clog2(OS_MAX + 1);
    localparam logic [SCW-1:0]  SER_LAST  = SCW'(SER_DIV - 1);
    localparam logic [CNTW-1:0] FIFO_FULL = CNTW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        SER_IDLE = 2'd0,
        SER_LOW  = 2'd1,
        SER_HIGH = 2'd2
    } ser_state_e;

    // Register words that carry meaning
    logic [31:0] reg0_s, reg1_s, reg2_s, reg3_s, reg4_s, reg5_s, reg6_s;
    assign reg0_s = reg_rw[31:0];
    assign reg1_s = reg_rw[63:32];
    assign reg2_s = reg_rw[95:64];
    assign reg3_s = reg_rw[127:96];
    assign reg4_s = reg_rw[159:128];
    assign reg5_s = reg_rw[191:160];
    assign reg6_s = reg_rw[223:192];

    logic unused_s;
    assign unused_s = ^{reg_rw[2047:224], reg0_s[31:26], reg0_s[23:7], reg0_s[4], reg0_s[1],
                        reg1_s[31:9], reg1_s[7:3], reg1_s[0], reg3_s[31:9], reg3_s[7:3],
                        reg3_s[0], reg5_s[31:1], reg6_s[31:1]};

    // Input staging
    logic        srst_r, trig_r;
    logic [8:0]  ctl_r, ctl_d_r, edge_s;
    logic [15:0] lvds_s1_r, lvds_s2_r, lvds_s3_r, lvds_edge_s;
    logic        dt_s1_r, dt_s2_r;

    // Register-bit staging, edge history and asynchronous-input synchronizers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            srst_r    <= 1'b0;
            trig_r    <= 1'b0;
            ctl_r     <= 9'd0;
            ctl_d_r   <= 9'd0;
            lvds_s1_r <= 16'd0;
            lvds_s2_r <= 16'd0;
            lvds_s3_r <= 16'd0;
            dt_s1_r   <= 1'b0;
            dt_s2_r   <= 1'b0;
        end else begin
            srst_r    <= reg0_s[0];
            trig_r    <= reg5_s[0];
            ctl_r     <= {reg6_s[0], reg3_s[8], reg3_s[2], reg3_s[1],
                          reg1_s[8], reg1_s[2], reg1_s[1], reg0_s[3], reg0_s[2]};
            ctl_d_r   <= ctl_r;
            lvds_s1_r <= oLVDS;
            lvds_s2_r <= lvds_s1_r;
            lvds_s3_r <= lvds_s2_r;
            dt_s1_r   <= opad_deltaT;
            dt_s2_r   <= dt_s1_r;
        end
    end

    // edge_s: 0 rst1, 1 rst2, 2 load1, 3 start1, 4 ld1, 5 load2, 6 start2, 7 ld2, 8 fifo read
    assign edge_s      = ctl_r & ~ctl_d_r;
    assign lvds_edge_s = lvds_s2_r & ~lvds_s3_r;

    // Timestamp
    logic [26:0] ts_r;

    // Free-running 27-bit timestamp, restarted by soft reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_r <= 27'd0;
        end else if (srst_r) begin
            ts_r <= 27'd0;
        end else begin
            ts_r <= ts_r + 27'd1;
        end
    end

    // Event arbitration: lowest pending channel wins each cycle
    logic [15:0] pending_r, grant_s;
    logic [3:0]  chan_s;
    assign grant_s = pending_r & (~pending_r + 16'd1);

    // Encode the one-hot grant into a channel number
    always_comb begin
        chan_s = 4'd0;
        for (int i = 0; i < 16; i++) begin
            chan_s = chan_s | (grant_s[i] ? 4'(i) : 4'd0);
        end
    end

    // Pending-channel set: edges arm, grants retire, trigger-off clears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= 16'd0;
        end else if (srst_r || !trig_r) begin
            pending_r <= 16'd0;
        end else begin
            pending_r <= (pending_r & ~grant_s) | lvds_edge_s;
        end
    end

    // Event FIFO
    logic [31:0]     fifo_mem_r [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CNTW-1:0] count_r, count_s;
    logic [31:0]     dout_r, fifo_word_s;
    logic            empty_r, full_r, ovf_r;
    logic            rd_req_s, wr_req_s, wr_ok_s, drop_s, is_full_s;

    assign fifo_word_s = {chan_s, dt_s2_r, ts_r};
    assign is_full_s   = (count_r == FIFO_FULL);
    assign rd_req_s    = edge_s[8] & (count_r != {CNTW{1'b0}});
    assign wr_req_s    = trig_r & (pending_r != 16'd0);
    assign wr_ok_s     = wr_req_s & (~is_full_s | rd_req_s);
    assign drop_s      = wr_req_s & is_full_s & ~rd_req_s;
    assign count_s     = count_r + CNTW'(wr_ok_s) - CNTW'(rd_req_s);

    // FIFO pointers, occupancy, read data and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CNTW{1'b0}};
            dout_r   <= 32'd0;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else if (srst_r) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CNTW{1'b0}};
            dout_r   <= 32'd0;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_req_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
                dout_r   <= fifo_mem_r[rd_ptr_r];
            end
            count_r <= count_s;
            empty_r <= (count_s == {CNTW{1'b0}});
            full_r  <= (count_s == FIFO_FULL);
            ovf_r   <= ovf_r | drop_s;
        end
    end

    // FIFO storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= 32'd0;
            end
        end else if (wr_ok_s && !srst_r) begin
            fifo_mem_r[wr_ptr_r] <= fifo_word_s;
        end
    end

    // Serial engines (index 0: reg1/reg2, index 1: reg3/reg4)
    ser_state_e      ser_state_r [2];
    ser_state_e      ser_state_s [2];
    logic [31:0]     ser_sr_r    [2];
    logic [31:0]     ser_sr_s    [2];
    logic [31:0]     ser_data_s  [2];
    logic [4:0]      ser_bit_r   [2];
    logic [4:0]      ser_bit_s   [2];
    logic [SCW-1:0]  ser_cnt_r   [2];
    logic [SCW-1:0]  ser_cnt_s   [2];
    logic [1:0]      ser_sdi_r, ser_sdi_s, ser_clk_r, ser_busy_r, ser_load_s, ser_start_s;

    assign ser_data_s[0] = reg2_s;
    assign ser_data_s[1] = reg4_s;
    assign ser_load_s    = {edge_s[5], edge_s[2]};
    assign ser_start_s   = {edge_s[6], edge_s[3]};

    // Serial next-state: each bit is SER_DIV cycles clock-low then SER_DIV clock-high
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            ser_state_s[k] = ser_state_r[k];
            ser_sr_s[k]    = ser_sr_r[k];
            ser_bit_s[k]   = ser_bit_r[k];
            ser_cnt_s[k]   = ser_cnt_r[k];
            ser_sdi_s[k]   = ser_sdi_r[k];
            case (ser_state_r[k])
                SER_IDLE: begin
                    ser_sr_s[k] = ser_load_s[k] ? ser_data_s[k] : ser_sr_r[k];
                    if (ser_start_s[k]) begin
                        ser_state_s[k] = SER_LOW;
                        ser_cnt_s[k]   = {SCW{1'b0}};
                        ser_bit_s[k]   = 5'd31;
                        ser_sdi_s[k]   = ser_sr_s[k][31];
                    end else begin
                        ser_sdi_s[k]   = 1'b0;
                    end
                end
                SER_LOW: begin
                    if (ser_cnt_r[k] == SER_LAST) begin
                        ser_state_s[k] = SER_HIGH;
                        ser_cnt_s[k]   = {SCW{1'b0}};
                    end else begin
                        ser_cnt_s[k]   = ser_cnt_r[k] + SCW'(1);
                    end
                end
                SER_HIGH: begin
                    if (ser_cnt_r[k] == SER_LAST) begin
                        ser_cnt_s[k] = {SCW{1'b0}};
                        if (ser_bit_r[k] == 5'd0) begin
                            ser_state_s[k] = SER_IDLE;
                            ser_sdi_s[k]   = 1'b0;
                        end else begin
                            ser_state_s[k] = SER_LOW;
                            ser_bit_s[k]   = ser_bit_r[k] - 5'd1;
                            ser_sr_s[k]    = {ser_sr_r[k][30:0], 1'b0};
                            ser_sdi_s[k]   = ser_sr_r[k][30];
                        end
                    end else begin
                        ser_cnt_s[k] = ser_cnt_r[k] + SCW'(1);
                    end
                end
                default: begin
                    ser_state_s[k] = SER_IDLE;
                    ser_sdi_s[k]   = 1'b0;
                end
            endcase
        end
    end

    // Serial state and registered pad outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                ser_state_r[k] <= SER_IDLE;
                ser_sr_r[k]    <= 32'd0;
                ser_bit_r[k]   <= 5'd0;
                ser_cnt_r[k]   <= {SCW{1'b0}};
            end
            ser_sdi_r  <= 2'd0;
            ser_clk_r  <= 2'd0;
            ser_busy_r <= 2'd0;
        end else if (srst_r) begin
            for (int k = 0; k < 2; k++) begin
                ser_state_r[k] <= SER_IDLE;
                ser_sr_r[k]    <= 32'd0;
                ser_bit_r[k]   <= 5'd0;
                ser_cnt_r[k]   <= {SCW{1'b0}};
            end
            ser_sdi_r  <= 2'd0;
            ser_clk_r  <= 2'd0;
            ser_busy_r <= 2'd0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                ser_state_r[k] <= ser_state_s[k];
                ser_sr_r[k]    <= ser_sr_s[k];
                ser_bit_r[k]   <= ser_bit_s[k];
                ser_cnt_r[k]   <= ser_cnt_s[k];
                ser_clk_r[k]   <= (ser_state_s[k] == SER_HIGH);
                ser_busy_r[k]  <= (ser_state_s[k] != SER_IDLE);
            end
            ser_sdi_r <= ser_sdi_s;
        end
    end

    // One-shots: 0 loadData, 1 loadData2, 2 RST_EXT, 3 RST_EXT2
    logic [OW-1:0] os_cnt_r [4];
    logic [OW-1:0] os_cnt_s [4];
    logic [3:0]    os_trig_s;
    logic [1:0]    load_data_r, rst_ext_r, startup_r;
    assign os_trig_s = {edge_s[1], edge_s[0], edge_s[7], edge_s[4]};

    // Retriggerable down-counters; a new edge reloads the full width
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            os_cnt_s[k] = os_cnt_r[k];
            if (os_trig_s[k]) begin
                os_cnt_s[k] = (k < 2) ? OW'(LOAD_PULSE) : OW'(RST_PULSE);
            end else if (os_cnt_r[k] != {OW{1'b0}}) begin
                os_cnt_s[k] = os_cnt_r[k] - OW'(1);
            end else begin
                os_cnt_s[k] = {OW{1'b0}};
            end
        end
    end

    // One-shot counters and registered pulse/level pads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                os_cnt_r[k] <= {OW{1'b0}};
            end
            load_data_r <= 2'd0;
            rst_ext_r   <= 2'd0;
            startup_r   <= 2'd0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                os_cnt_r[k] <= (srst_r && k < 2) ? {OW{1'b0}} : os_cnt_s[k];
            end
            for (int k = 0; k < 2; k++) begin
                load_data_r[k] <= !srst_r && (os_cnt_s[k] != {OW{1'b0}});
                rst_ext_r[k]   <= (os_cnt_s[k+2] != {OW{1'b0}}) | reg0_s[5+k];
            end
            startup_r <= {reg0_s[25], reg0_s[24]};
        end
    end

    assign fifo_dout      = dout_r;
    assign fifo_empty     = empty_r;
    assign fifo_full      = full_r;
    assign fifo_ovf       = ovf_r;
    assign fifo_count     = 5'(count_r);
    assign opad_CLKin     = ser_clk_r[0];
    assign opad_SDI       = ser_sdi_r[0];
    assign opad_loadData  = load_data_r[0];
    assign opad_CLKin2    = ser_clk_r[1];
    assign opad_SDI2      = ser_sdi_r[1];
    assign opad_loadData2 = load_data_r[1];
    assign shift_busy     = ser_busy_r[0];
    assign shift_busy2    = ser_busy_r[1];
    assign opad_RST_EXT   = rst_ext_r[0];
    assign opad_RST_EXT2  = rst_ext_r[1];
    assign opad_startup   = startup_r[0];
    assign opad_startup2  = startup_r[1];

endmodule

// File: tb/tb_qpix_top_rtl.sv
// Self-checking bench for qpix_top_rtl: randomized event/serial stimulus with
// expectations computed from the block's behavioural rules.
module tb_qpix_top_rtl;

    localparam int SER_DIV    = 4;
    localparam int LOAD_PULSE = 16;
    localparam int RST_PULSE  = 8;
    localparam int FIFO_DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   oLVDS = 16'd0;
    logic          opad_deltaT = 1'b0;
    logic [2047:0] reg_rw = '0;
    logic [31:0]   fifo_dout;
    logic          fifo_empty, fifo_full, fifo_ovf;
    logic [4:0]    fifo_count;
    logic          opad_CLKin, opad_SDI, opad_loadData;
    logic          opad_CLKin2, opad_SDI2, opad_loadData2;
    logic          shift_busy, shift_busy2;
    logic          opad_RST_EXT, opad_RST_EXT2, opad_startup, opad_startup2;

    qpix_top_rtl #(
        .SER_DIV(SER_DIV), .LOAD_PULSE(LOAD_PULSE), .RST_PULSE(RST_PULSE), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .oLVDS(oLVDS), .opad_deltaT(opad_deltaT), .reg_rw(reg_rw),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .fifo_ovf(fifo_ovf), .fifo_count(fifo_count),
        .opad_CLKin(opad_CLKin), .opad_SDI(opad_SDI), .opad_loadData(opad_loadData),
        .opad_CLKin2(opad_CLKin2), .opad_SDI2(opad_SDI2), .opad_loadData2(opad_loadData2),
        .shift_busy(shift_busy), .shift_busy2(shift_busy2),
        .opad_RST_EXT(opad_RST_EXT), .opad_RST_EXT2(opad_RST_EXT2),
        .opad_startup(opad_startup), .opad_startup2(opad_startup2)
    );

    always #10 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int pulses [2];
    logic [31:0] capt [2];
    logic [1:0] prev_sclk = 2'b00;
    int ld_hi [2];
    int rst_hi [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Per-cycle compare process: sample request levels at the edge, check outputs just after
    always @(posedge clk) begin
        logic s24, s25, rn;
        logic [1:0] sc, sd;
        s24 = reg_rw[24];
        s25 = reg_rw[25];
        rn  = rst_n;
        #2;
        if (rn) begin
            chk("startup_lvl", {31'd0, opad_startup}, {31'd0, s24});
            chk("startup2_lvl", {31'd0, opad_startup2}, {31'd0, s25});
        end
        chk("empty_vs_count", {31'd0, fifo_empty}, {31'd0, fifo_count == 5'd0});
        chk("full_vs_count", {31'd0, fifo_full}, {31'd0, fifo_count == 5'(FIFO_DEPTH)});
        sc = {opad_CLKin2, opad_CLKin};
        sd = {opad_SDI2, opad_SDI};
        for (int k = 0; k < 2; k++) begin
            if (sc[k] && !prev_sclk[k]) begin
                pulses[k]++;
                capt[k] = {capt[k][30:0], sd[k]};
            end
        end
        prev_sclk = sc;
        if (opad_loadData)  ld_hi[0]++;
        if (opad_loadData2) ld_hi[1]++;
        if (opad_RST_EXT)   rst_hi[0]++;
        if (opad_RST_EXT2)  rst_hi[1]++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_reg(input int w, input int b, input logic v);
        reg_rw[w*32+b] = v;
    endtask

    task automatic pulse_reg(input int w, input int b);
        set_reg(w, b, 1'b1);
        tick(2);
        set_reg(w, b, 1'b0);
        tick(2);
    endtask

    task automatic soft_reset();
        set_reg(0, 0, 1'b1);
        tick(3);
        set_reg(0, 0, 1'b0);
        tick(2);
    endtask

    task automatic read_word(output logic [31:0] w);
        set_reg(6, 0, 1'b1);
        tick(2);
        set_reg(6, 0, 1'b0);
        tick(3);
        w = fifo_dout;
    endtask

    task automatic lvds_pulse(input logic [15:0] m);
        oLVDS = m;
        tick(2);
        oLVDS = 16'd0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_dout"}, fifo_dout, 32'd0);
        chk({tag, "_flags"}, {26'd0, fifo_empty, fifo_full, fifo_ovf, 3'd0}, 32'h20);
        chk({tag, "_count"}, {27'd0, fifo_count}, 32'd0);
        chk({tag, "_pads"}, {18'd0, opad_CLKin, opad_SDI, opad_loadData, opad_CLKin2, opad_SDI2,
             opad_loadData2, shift_busy, shift_busy2, opad_RST_EXT, opad_RST_EXT2,
             opad_startup, opad_startup2, 2'd0}, 32'd0);
    endtask

    task automatic run_serial(input int ifc, input logic [31:0] data, input bit disturb);
        int ctl, dat;
        logic b;
        ctl = (ifc == 0) ? 1 : 3;
        dat = (ifc == 0) ? 2 : 4;
        reg_rw[dat*32 +: 32] = data;
        tick(2);
        pulse_reg(ctl, 1);
        reg_rw[dat*32 +: 32] = ~data;
        pulses[ifc] = 0;
        capt[ifc]   = 32'd0;
        set_reg(ctl, 2, 1'b1);
        for (int i = 0; i < 10; i++) begin
            b = (ifc == 0) ? shift_busy : shift_busy2;
            if (!b) tick(1);
        end
        if (disturb) begin
            tick(20);
            set_reg(ctl, 2, 1'b0);
            pulse_reg(ctl, 1);
        end
        for (int i = 0; i < 600; i++) begin
            b = (ifc == 0) ? shift_busy : shift_busy2;
            if (b) tick(1);
        end
        set_reg(ctl, 2, 1'b0);
        tick(3);
        b = (ifc == 0) ? shift_busy : shift_busy2;
        chk("ser_done", {31'd0, b}, 32'd0);
        chk("ser_pulses", pulses[ifc], 32'd32);
        chk("ser_word", capt[ifc], data);
        chk("ser_idle_pads", (ifc == 0) ? {30'd0, opad_CLKin, opad_SDI} : {30'd0, opad_CLKin2, opad_SDI2}, 32'd0);
    endtask

    initial begin
        logic [31:0] w, prev;
        logic [26:0] prev_ts;
        int t [4];
        logic [15:0] mask;
        logic dt;
        bit first;
        localparam int D = 4;

        pulses[0] = 0; pulses[1] = 0; capt[0] = 0; capt[1] = 0;
        ld_hi[0] = 0; ld_hi[1] = 0; rst_hi[0] = 0; rst_hi[1] = 0;

        // reset state
        tick(3);
        check_idle("rst_async");
        rst_n = 1'b1;
        tick(3);
        soft_reset();
        check_idle("rst_soft");

        // timestamp restarts from zero after soft reset
        set_reg(5, 0, 1'b1);
        set_reg(0, 0, 1'b1);
        tick(3);
        set_reg(0, 0, 1'b0);
        tick(D);
        lvds_pulse(16'h0001);
        tick(6);
        read_word(w);
        chk("ts_restart", {31'd0, (w[26:0] >= 27'(D)) && (w[26:0] <= 27'(D + 6))}, 32'd1);
        chk("ts_restart_hdr", {28'd0, w[31:28]}, 32'd0);
        chk("ts_restart_dt", {31'd0, w[27]}, 32'd0);

        // four pulses on channel 0 with deltaT = 1
        opad_deltaT = 1'b1;
        tick(4);
        for (int i = 0; i < 4; i++) begin
            t[i] = cyc;
            lvds_pulse(16'h0001);
            tick($urandom_range(3, 10));
        end
        tick(6);
        chk("four_count", {27'd0, fifo_count}, 32'd4);
        for (int i = 0; i < 4; i++) begin
            read_word(w);
            chk("four_chan", {28'd0, w[31:28]}, 32'd0);
            chk("four_dt", {31'd0, w[27]}, 32'd1);
            if (i > 0) chk("four_ts_step", {5'd0, w[26:0] - prev_ts}, {5'd0, 27'(t[i] - t[i-1])});
            prev_ts = w[26:0];
        end
        prev = fifo_dout;
        read_word(w);
        chk("empty_read_dout", w, prev);
        chk("empty_read_flag", {31'd0, fifo_empty}, 32'd1);
        chk("empty_read_count", {27'd0, fifo_count}, 32'd0);

        // simultaneous edges: fixed 0/1/5 then random masks
        for (int r = 0; r < 4; r++) begin
            mask = (r == 0) ? 16'h0023 : 16'($urandom_range(1, 65535));
            dt = 1'($urandom_range(0, 1));
            opad_deltaT = dt;
            tick(4);
            lvds_pulse(mask);
            tick(25);
            chk("multi_count", {27'd0, fifo_count}, $countones(mask));
            first = 1'b1;
            for (int ch = 0; ch < 16; ch++) begin
                if (mask[ch]) begin
                    read_word(w);
                    chk("multi_chan", {28'd0, w[31:28]}, ch);
                    chk("multi_dt", {31'd0, w[27]}, {31'd0, dt});
                    if (!first) chk("multi_ts_step", {5'd0, w[26:0] - prev_ts}, 32'd1);
                    prev_ts = w[26:0];
                    first = 1'b0;
                end
            end
            chk("multi_drained", {31'd0, fifo_empty}, 32'd1);
        end

        // 17 events with no reads: overflow
        for (int i = 0; i < 17; i++) begin
            lvds_pulse(16'h0008);
            tick(3);
        end
        tick(6);
        chk("ovf_full", {31'd0, fifo_full}, 32'd1);
        chk("ovf_flag", {31'd0, fifo_ovf}, 32'd1);
        chk("ovf_count", {27'd0, fifo_count}, 32'd16);
        soft_reset();
        chk("ovf_cleared", {30'd0, fifo_ovf, fifo_empty}, 32'd1);
        chk("ovf_cleared_count", {27'd0, fifo_count}, 32'd0);
        set_reg(5, 0, 1'b0);

        // trigger off: edges are ignored
        lvds_pulse(16'h00F0);
        tick(8);
        chk("trig_off_count", {27'd0, fifo_count}, 32'd0);

        // serial interfaces
        run_serial(0, 32'h12345678, 1'b0);
        run_serial(1, 32'hA0A0A0AF, 1'b0);
        run_serial(0, $urandom, 1'b1);
        run_serial(1, $urandom, 1'b1);

        // loadData one-shots, including a retrigger
        ld_hi[0] = 0;
        pulse_reg(1, 8);
        tick(25);
        chk("load1_width", ld_hi[0], LOAD_PULSE);
        ld_hi[1] = 0;
        pulse_reg(3, 8);
        tick(25);
        chk("load2_width", ld_hi[1], LOAD_PULSE);
        ld_hi[0] = 0;
        set_reg(1, 8, 1'b1); tick(1); set_reg(1, 8, 1'b0); tick(5);
        set_reg(1, 8, 1'b1); tick(1); set_reg(1, 8, 1'b0); tick(30);
        chk("load1_retrig", ld_hi[0], 6 + LOAD_PULSE);

        // reset pads: one-shot and level
        rst_hi[0] = 0;
        pulse_reg(0, 2);
        tick(15);
        chk("rst1_pulse", rst_hi[0], RST_PULSE);
        rst_hi[1] = 0;
        pulse_reg(0, 3);
        tick(15);
        chk("rst2_pulse", rst_hi[1], RST_PULSE);
        rst_hi[0] = 0;
        set_reg(0, 5, 1'b1); tick(10); set_reg(0, 5, 1'b0); tick(5);
        chk("rst1_level", rst_hi[0], 10);
        rst_hi[1] = 0;
        set_reg(0, 6, 1'b1); tick(10); set_reg(0, 6, 1'b0); tick(5);
        chk("rst2_level", rst_hi[1], 10);

        // static startup levels, one cycle latency
        set_reg(0, 24, 1'b1);
        set_reg(0, 25, 1'b1);
        @(posedge clk);
        #2;
        chk("startup_set", {30'd0, opad_startup2, opad_startup}, 32'd3);
        tick(3);
        set_reg(0, 24, 1'b0);
        tick(3);
        chk("startup_clr", {30'd0, opad_startup2, opad_startup}, 32'd2);

        tick(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
